// File: rtl/rice_partition_optimizer.sv
// Rice-parameter optimiser: costs every parameter 0..MAX_PARAM over a partition and reports the cheapest.
// Latency: oValid is high after edge E0+MAX_PARAM+4, where E0 accepts the closing sample (E0+MAX_PARAM+3 for a bare flush).
// Backpressure: oReady drops only when a partition closes while the previous one is still being scanned.
//
// Ports: iClock/iReset_n (sync, active-low); iValid/iResidual/iFlush in, accepted while oReady;
//        oValid pulses with oBest (5'h1F = escape), oBits (cost excluding the parameter field),
//        oCount (samples in the partition) and oEscape.
// Optional build macro RICE_ESCAPE_EN adds the verbatim (escape) coding decision after the scan.
module rice_partition_optimizer #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int PARTITION_SIZE = 1024,
  parameter int MAX_PARAM      = 14,
  parameter int ACC_WIDTH      = SAMPLE_WIDTH + $clog2(PARTITION_SIZE) + 2
) (
  input  logic                                iClock,
  input  logic                                iReset_n,
  input  logic                                iValid,
  input  logic signed [SAMPLE_WIDTH-1:0]      iResidual,
  input  logic                                iFlush,
  output logic                                oReady,
  output logic                                oValid,
  output logic [4:0]                          oBest,
  output logic [ACC_WIDTH-1:0]                oBits,
  output logic [$clog2(PARTITION_SIZE+1)-1:0] oCount,
  output logic                                oEscape
);

  localparam int CW = $clog2(PARTITION_SIZE + 1);
  localparam int KW = $clog2(MAX_PARAM + 1);
  localparam int UW = SAMPLE_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        count_q, count_d;
  logic [UW-1:0]        u_q, u_d;
  logic                 s1_vld_q, s1_vld_d;
  logic                 s1_last_q, s1_last_d;
  logic [CW-1:0]        s1_cnt_q, s1_cnt_d;
  logic                 s2_last_q, s2_last_d;
  logic [CW-1:0]        s2_cnt_q, s2_cnt_d;
  logic                 pend_q, pend_d;
  logic [ACC_WIDTH-1:0] acc_q [0:MAX_PARAM];
  logic [ACC_WIDTH-1:0] acc_d [0:MAX_PARAM];
  logic [ACC_WIDTH-1:0] snap_q [0:MAX_PARAM];
  logic [ACC_WIDTH-1:0] snap_d [0:MAX_PARAM];
  logic [CW-1:0]        snap_cnt_q, snap_cnt_d;
  logic [ACC_WIDTH-1:0] min_q, min_d;
  logic [KW-1:0]        best_q, best_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [4:0]           obest_q, obest_d;
  logic [ACC_WIDTH-1:0] obits_q, obits_d;
  logic [CW-1:0]        ocount_q, ocount_d;

  logic          accept_s, accept_f;
  logic [CW-1:0] cnt_next;
  logic          close_any, flush_only;
  logic          load, busy_pred;
  logic [UW-1:0] u_in;

  assign accept_s   = iValid && ready_q;
  assign accept_f   = iFlush && ready_q;
  assign cnt_next   = count_q + CW'(accept_s);
  assign close_any  = (accept_s && (cnt_next == CW'(PARTITION_SIZE))) ||
                      (accept_f && (cnt_next != '0));
  // A bare flush skips stage 1: the last sample is already in (or entering) the accumulators.
  assign flush_only = close_any && !accept_s;

  // Zigzag fold: non-negative r -> 2r, negative r -> -2r-1.
  assign u_in = {iResidual, 1'b0} ^ {UW{iResidual[SAMPLE_WIDTH-1]}};

  // Snapshot loads from the closing sample leaving stage 2, or from a held (stalled) partition.
  assign load = (s2_last_q || pend_q) && (state_q == ST_IDLE);

  // Predicts whether the snapshot will still be busy when this close reaches it:
  // a sample close needs it two edges out, a bare flush one edge out.
  assign busy_pred = pend_q || s1_last_q || s2_last_q ||
                     ((state_q == ST_SCAN) && (flush_only || (k_q != KW'(MAX_PARAM))));

`ifdef RICE_ESCAPE_EN
  logic                 escape_q, escape_d;
  logic [ACC_WIDTH-1:0] esc_bits;
  assign esc_bits = ACC_WIDTH'(5) + ACC_WIDTH'(snap_cnt_q) * ACC_WIDTH'(SAMPLE_WIDTH);
  assign oEscape  = escape_q;
`else
  assign oEscape  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    snap_d     = snap_q;
    snap_cnt_d = snap_cnt_q;
    min_d      = min_q;
    best_d     = best_q;
    valid_d    = 1'b0;
    obest_d    = obest_q;
    obits_d    = obits_q;
    ocount_d   = ocount_q;
`ifdef RICE_ESCAPE_EN
    escape_d   = escape_q;
`endif

    // Input side: count, stage 1 and the close marker travelling with the pipe.
    count_d   = close_any ? '0 : cnt_next;
    s1_vld_d  = accept_s;
    u_d       = accept_s ? u_in : u_q;
    s1_last_d = accept_s && close_any;
    s1_cnt_d  = accept_s ? cnt_next : s1_cnt_q;
    s2_last_d = s1_last_q || flush_only;
    s2_cnt_d  = s2_cnt_q;
    if (flush_only) begin
      s2_cnt_d = count_q;
    end else if (s1_last_q) begin
      s2_cnt_d = s1_cnt_q;
    end

    // A close that finds the snapshot busy holds the totals until it frees.
    if (load) begin
      pend_d = 1'b0;
    end else if (s2_last_q) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    for (int k = 0; k <= MAX_PARAM; k++) begin
      acc_d[k] = (load ? '0 : acc_q[k]) +
                 (s1_vld_q ? (ACC_WIDTH'(u_q >> k) + ACC_WIDTH'(k + 1)) : '0);
    end

    ready_d = ready_q;
    if (close_any && busy_pred) begin
      ready_d = 1'b0;
    end else if (load && pend_q) begin
      ready_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          snap_d     = acc_q;
          snap_cnt_d = s2_cnt_q;
          k_d        = '0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Strictly-less keeps the lowest k on ties; k=0 seeds the minimum.
        if ((k_q == '0) || (snap_q[k_q] < min_q)) begin
          min_d  = snap_q[k_q];
          best_d = k_q;
        end
        if (k_q == KW'(MAX_PARAM)) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        obest_d  = 5'(best_q);
        obits_d  = min_q;
        ocount_d = snap_cnt_q;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
`ifdef RICE_ESCAPE_EN
        escape_d = 1'b0;
        if (esc_bits < min_q) begin
          escape_d = 1'b1;
          obest_d  = 5'h1F;
          obits_d  = esc_bits;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      count_q    <= '0;
      u_q        <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_cnt_q   <= '0;
      s2_last_q  <= 1'b0;
      s2_cnt_q   <= '0;
      pend_q     <= 1'b0;
      for (int k = 0; k <= MAX_PARAM; k++) begin
        acc_q[k]  <= '0;
        snap_q[k] <= '0;
      end
      snap_cnt_q <= '0;
      min_q      <= '0;
      best_q     <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      obest_q    <= '0;
      obits_q    <= '0;
      ocount_q   <= '0;
`ifdef RICE_ESCAPE_EN
      escape_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      count_q    <= count_d;
      u_q        <= u_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s1_cnt_q   <= s1_cnt_d;
      s2_last_q  <= s2_last_d;
      s2_cnt_q   <= s2_cnt_d;
      pend_q     <= pend_d;
      acc_q      <= acc_d;
      snap_q     <= snap_d;
      snap_cnt_q <= snap_cnt_d;
      min_q      <= min_d;
      best_q     <= best_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      obest_q    <= obest_d;
      obits_q    <= obits_d;
      ocount_q   <= ocount_d;
`ifdef RICE_ESCAPE_EN
      escape_q   <= escape_d;
`endif
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oBest  = obest_q;
  assign oBits  = obits_q;
  assign oCount = ocount_q;

endmodule

// File: tb/tb_rice_partition_optimizer.sv
// Self-checking bench for rice_partition_optimizer: random and directed residual streams
// compared against a plain-arithmetic cost model and an event-timeline model of ready/valid timing.
// Honours RICE_ESCAPE_EN in the model when the build defines it.
module tb_rice_partition_optimizer;

  localparam int SW = 16;
  localparam int PS = 18;
  localparam int MP = 14;
  localparam int AW = SW + $clog2(PS) + 2;
  localparam int CW = $clog2(PS + 1);

  logic          iClock;
  logic          iReset_n;
  logic          iValid;
  logic [SW-1:0] iResidual;
  logic          iFlush;
  logic          oReady;
  logic          oValid;
  logic [4:0]    oBest;
  logic [AW-1:0] oBits;
  logic [CW-1:0] oCount;
  logic          oEscape;

  rice_partition_optimizer #(
    .SAMPLE_WIDTH  (SW),
    .PARTITION_SIZE(PS),
    .MAX_PARAM     (MP)
  ) dut (
    .iClock   (iClock),
    .iReset_n (iReset_n),
    .iValid   (iValid),
    .iResidual(iResidual),
    .iFlush   (iFlush),
    .oReady   (oReady),
    .oValid   (oValid),
    .oBest    (oBest),
    .oBits    (oBits),
    .oCount   (oCount),
    .oEscape  (oEscape)
  );

  typedef struct {
    int     best;
    longint bits;
    int     cnt;
    int     esc;
    int     vedge;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   part[$];
  exp_t expq[$];
  exp_t mon_e;
  int   prev_valid = -100;
  int   stall_e0 = 0;
  int   stall_snap = 0;

  initial begin
    iClock = 1'b0;
    forever #5 iClock = ~iClock;
  end

  always @(posedge iClock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cost of each parameter straight from the definition: sum of (u>>k)+k+1 per sample.
  function automatic exp_t model(input int n);
    exp_t   e;
    longint c;
    longint best_c = 0;
    int     best = 0;
    int     u;
    for (int k = 0; k <= MP; k++) begin
      c = 0;
      foreach (part[i]) begin
        u = (part[i] >= 0) ? 2 * part[i] : -2 * part[i] - 1;
        c += longint'(u >> k) + k + 1;
      end
      if (k == 0 || c < best_c) begin
        best_c = c;
        best   = k;
      end
    end
    e.best  = best;
    e.bits  = best_c;
    e.cnt   = n;
    e.esc   = 0;
    e.vedge = 0;
`ifdef RICE_ESCAPE_EN
    if (longint'(5 + n * SW) < best_c) begin
      e.best = 31;
      e.bits = 5 + n * SW;
      e.esc  = 1;
    end
`endif
    return e;
  endfunction

  // One clock of stimulus. The timeline model decides acceptance: the snapshot loads at the
  // natural edge unless the previous result has not been delivered yet, in which case input stalls.
  task automatic step(input bit v, input int r, input bit f);
    bit   rdy;
    bit   close;
    int   e0;
    int   natural;
    int   snap;
    exp_t e;
    rdy = !(cyc >= stall_e0 && cyc < stall_snap);
    check_eq("ready", oReady, rdy);
    iValid    = v;
    iResidual = r[SW-1:0];
    iFlush    = f;
    if (rdy) begin
      e0 = cyc + 1;
      if (v) part.push_back(r);
      close = (v && part.size() == PS) || (f && part.size() > 0);
      if (close) begin
        natural = e0 + (v ? 2 : 1);
        snap    = (natural > prev_valid + 1) ? natural : prev_valid + 1;
        e       = model(part.size());
        e.vedge = snap + MP + 2;
        prev_valid = e.vedge;
        if (snap > natural) begin
          stall_e0   = e0;
          stall_snap = snap;
        end
        expq.push_back(e);
        part.delete();
      end
    end
    @(posedge iClock);
    #1;
    iValid = 1'b0;
    iFlush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic reset_dut();
    iReset_n = 1'b0;
    iValid   = 1'b0;
    iFlush   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge iClock);
      #1;
    end
    part.delete();
    expq.delete();
    prev_valid = -100;
    stall_e0   = 0;
    stall_snap = 0;
    iReset_n   = 1'b1;
    check_eq("rst_ready", oReady, 1);
    check_eq("rst_valid", oValid, 0);
    check_eq("rst_best", oBest, 0);
    check_eq("rst_bits", oBits, 0);
    check_eq("rst_count", oCount, 0);
    check_eq("rst_escape", oEscape, 0);
  endtask

  function automatic int rnd_res();
    int sh;
    int r;
    sh = $urandom_range(0, 15);
    r  = int'($urandom_range(0, (1 << sh) - 1));
    if ($urandom_range(0, 1) == 1) r = -r - 1;
    return r;
  endfunction

  always @(negedge iClock) begin
    if (iReset_n && oValid) begin
      if (expq.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        check_eq("best", oBest, mon_e.best);
        check_eq("bits", oBits, mon_e.bits);
        check_eq("count", oCount, mon_e.cnt);
        check_eq("escape", oEscape, mon_e.esc);
        check_eq("valid_edge", cyc, mon_e.vedge);
      end
    end
  end

  initial begin
    int w;
    iReset_n  = 1'b0;
    iValid    = 1'b0;
    iFlush    = 1'b0;
    iResidual = '0;
    reset_dut();

    // Directed partitions of 16, closed by a flush riding on the last sample.
    for (int i = 0; i < 16; i++) step(1'b1, 0, i == 15);
    idle(22);
    for (int i = 0; i < 16; i++) step(1'b1, 100, i == 15);
    idle(22);
    for (int i = 0; i < 16; i++) step(1'b1, -1, i == 15);
    idle(22);
    // Short partition closed by a bare flush, then a flush on an empty partition.
    for (int i = 0; i < 5; i++) step(1'b1, 100, 1'b0);
    step(1'b0, 0, 1'b1);
    idle(22);
    step(1'b0, 0, 1'b1);
    idle(22);
    // Full-scale alternating residuals (escape candidate).
    for (int i = 0; i < 16; i++) step(1'b1, (i % 2 == 1) ? -32767 : 32767, i == 15);
    idle(22);

    // Back-to-back full partitions, then a 1-sample partition flushed during the scan.
    for (int i = 0; i < 3 * PS; i++) step(1'b1, rnd_res(), 1'b0);
    step(1'b1, rnd_res(), 1'b1);
    for (int i = 0; i < 30; i++) step(1'b1, rnd_res(), 1'b0);

    // Random traffic with sporadic flushes.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rnd_res(), $urandom_range(0, 19) == 0);
    end
    step(1'b0, 0, 1'b1);
    idle(40);

    // Reset during a scan: the pending result must never appear.
    for (int i = 0; i < 10; i++) step(1'b1, rnd_res(), i == 9);
    idle(6);
    reset_dut();
    idle(40);

    w = 0;
    while (expq.size() != 0 && w < 200) begin
      idle(1);
      w++;
    end
    check_eq("drain", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
